// File: rtl/dmem_responder_if.sv
// dmem_responder_if -- backend request/response and memory-side bus bundle
// for the dmem_responder block.
//
// Handshakes:
//   Backend: a request is taken on a clk edge where req_valid and req_ready
//   are both 1. req_ready is 1 only while the responder is idle. The request
//   fields only need to be valid in that cycle. resp_valid is a single-cycle
//   pulse and is never back-pressured.
//   Memory: bus_req stays high with stable bus_wr/bus_addr/bus_wstrb/
//   bus_wdata until the cycle bus_addr_ok is 1. The transfer completes in the
//   cycle bus_data_ok is 1, which is the same cycle or any later one, and
//   bus_rdata is valid in that cycle.
interface dmem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // backend request side
  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [3:0]        req_wstrb;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;
  // backend response side
  logic              flush;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  // memory side
  logic              bus_req;
  logic              bus_wr;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_wstrb;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_addr_ok;
  logic              bus_data_ok;
  logic [DATA_W-1:0] bus_rdata;

  // master: backend plus memory model (the environment around the responder)
  modport master (
    output req_valid, req_we, req_addr, req_wstrb, req_wdata, flush,
           bus_addr_ok, bus_data_ok, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata
  );

  // slave: the responder itself
  modport slave (
    input  req_valid, req_we, req_addr, req_wstrb, req_wdata, flush,
           bus_addr_ok, bus_data_ok, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder -- single-outstanding data-memory responder. It takes one
// load/store from the backend, runs one address phase and one data phase on
// the memory bus, and returns a single-cycle response pulse.
//
// Optional feature: define DMEM_TIMEOUT_EN to build a bus watchdog. The
// watchdog ends a stuck transaction after TIMEOUT_CYC cycles in the address
// and data phases and reports it with resp_err=1. Without the macro there is
// no counter, resp_err is tied low, and the FSM waits indefinitely.
//
// Only DATA_W = 32 is supported because byte enables are fixed at 4 bits.
module dmem_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  dmem_responder_if.slave      dmem,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Word alignment mask for the memory-side address.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_we;        // latched store/load select, drives bus_wr
  logic [ADDR_W-1:0] r_addr;      // latched byte address
  logic [3:0]        r_wstrb;
  logic [DATA_W-1:0] r_wdata;
  logic              r_bus_req;
  logic              r_cancel;    // flush seen while this transaction was on the bus
  logic              r_resp_pend; // a response is due in RESP (not cancelled)
  logic [DATA_W-1:0] r_resp_rdata;
  logic              w_resp_allow;

  // A response survives only if nothing cancelled it, including a flush in
  // the same cycle that the FSM moves into RESP.
  assign w_resp_allow = !(r_cancel || dmem.flush);

`ifdef DMEM_TIMEOUT_EN
  localparam int WDOG_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

  logic [WDOG_W-1:0] r_wdog;
  logic              r_err;
`endif

  // Main FSM: sequences the bus transaction and registers all bus and
  // response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_req_ready  <= 1'b1;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wstrb      <= '0;
      r_wdata      <= '0;
      r_bus_req    <= 1'b0;
      r_cancel     <= 1'b0;
      r_resp_pend  <= 1'b0;
      r_resp_rdata <= '0;
`ifdef DMEM_TIMEOUT_EN
      r_wdog       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          // A flush in the same cycle drops the request without a trace.
          if (dmem.req_valid && !dmem.flush) begin
            r_we        <= dmem.req_we;
            r_addr      <= dmem.req_addr;
            r_wstrb     <= dmem.req_wstrb;
            r_wdata     <= dmem.req_wdata;
            r_bus_req   <= 1'b1;
            r_req_ready <= 1'b0;
            r_cancel    <= 1'b0;
            r_state     <= S_ADDR;
`ifdef DMEM_TIMEOUT_EN
            r_wdog      <= '0;
`endif
          end
        end

        S_ADDR: begin
          if (dmem.flush) r_cancel <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
          r_wdog <= r_wdog + 1'b1;
`endif
          if (dmem.bus_addr_ok && dmem.bus_data_ok) begin
            // Address and data phases together: data is delivered now.
            r_bus_req    <= 1'b0;
            r_resp_pend  <= w_resp_allow;
            r_resp_rdata <= r_we ? '0 : dmem.bus_rdata;
            r_state      <= S_RESP;
          end else if (dmem.bus_addr_ok) begin
            r_bus_req <= 1'b0;
            r_state   <= S_DATA;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (r_wdog == WDOG_LAST) begin
            r_bus_req    <= 1'b0;
            r_resp_pend  <= w_resp_allow;
            r_resp_rdata <= '0;
            r_err        <= 1'b1;
            r_state      <= S_RESP;
          end
`endif
        end

        S_DATA: begin
          if (dmem.flush) r_cancel <= 1'b1;
`ifdef DMEM_TIMEOUT_EN
          r_wdog <= r_wdog + 1'b1;
`endif
          if (dmem.bus_data_ok) begin
            r_resp_pend  <= w_resp_allow;
            r_resp_rdata <= r_we ? '0 : dmem.bus_rdata;
            r_state      <= S_RESP;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (r_wdog == WDOG_LAST) begin
            r_resp_pend  <= w_resp_allow;
            r_resp_rdata <= '0;
            r_err        <= 1'b1;
            r_state      <= S_RESP;
          end
`endif
        end

        S_RESP: begin
          // The response lasts one cycle. Clear it on the way back to idle.
          r_resp_pend  <= 1'b0;
          r_resp_rdata <= '0;
          r_cancel     <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
`ifdef DMEM_TIMEOUT_EN
          r_err        <= 1'b0;
`endif
        end

        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_bus_req   <= 1'b0;
        end
      endcase
    end
  end

  // A flush during the RESP cycle itself must still suppress the pulse, so
  // it gates the registered pending bit directly.
  assign dmem.resp_valid = r_resp_pend && !dmem.flush;
  assign dmem.resp_rdata = r_resp_rdata;
`ifdef DMEM_TIMEOUT_EN
  assign dmem.resp_err   = r_err;
`else
  assign dmem.resp_err   = 1'b0;
`endif

  assign dmem.req_ready  = r_req_ready;
  assign dmem.bus_req    = r_bus_req;
  assign dmem.bus_wr     = r_we;
  assign dmem.bus_addr   = r_addr & ALIGN_MASK;
  assign dmem.bus_wstrb  = r_wstrb;
  assign dmem.bus_wdata  = r_wdata;

  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder -- directed and randomized bench for dmem_responder.
// Expected bus and response timing comes from transaction-level arithmetic.
// Expected response data is kept in a scoreboard queue.
module tb_dmem_responder;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  dmem_responder_if #(.ADDR_W(32), .DATA_W(32)) dif ();

  dmem_responder #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dmem        (dif.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // Global time bound: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end of test, required end before 200000");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    dif.req_valid   = 1'b0;
    dif.req_we      = 1'b0;
    dif.req_addr    = '0;
    dif.req_wstrb   = '0;
    dif.req_wdata   = '0;
    dif.flush       = 1'b0;
    dif.bus_addr_ok = 1'b0;
    dif.bus_data_ok = 1'b0;
    dif.bus_rdata   = '0;
  endtask

  // Runs one complete transaction. It starts just after a negedge with the
  // DUT idle and returns just after the negedge of the first idle cycle that
  // follows.
  //   ad    : ADDR cycles without addr_ok before the one that grants it
  //   dd    : DATA cycles without data_ok before the one that completes it
  //   same  : addr_ok and data_ok arrive in the same cycle (dd is ignored)
  //   fl_at : cycle after acceptance that carries flush (0 = none)
  task automatic run_txn(input logic we, input logic [31:0] addr,
                         input logic [3:0] wstrb, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ad, input int dd,
                         input bit same, input int fl_at);
    int  addr_last, data_cyc, resp_cyc;
    bit  cancel, exp_rv;
    logic [31:0] word;
    addr_last = ad + 1;
    data_cyc  = same ? addr_last : (ad + 2 + dd);
    resp_cyc  = data_cyc + 1;
    cancel    = (fl_at >= 1) && (fl_at <= resp_cyc);
    if (!cancel) exp_q.push_back(we ? 32'h0 : rdata);

    dif.req_valid = 1'b1;
    dif.req_we    = we;
    dif.req_addr  = addr;
    dif.req_wstrb = wstrb;
    dif.req_wdata = wdata;
    #1;
    chk("accept_ready", dif.req_ready, 1'b1);
    @(posedge clk);

    for (int c = 1; c <= resp_cyc; c++) begin
      @(negedge clk);
      // Keep a different request on the inputs: it must be ignored.
      dif.req_valid   = 1'b1;
      dif.req_we      = ~we;
      dif.req_addr    = $urandom;
      dif.req_wstrb   = 4'($urandom);
      dif.req_wdata   = $urandom;
      dif.flush       = (c == fl_at);
      dif.bus_addr_ok = (c == addr_last);
      dif.bus_data_ok = (c == data_cyc);
      dif.bus_rdata   = (c == data_cyc) ? rdata : $urandom;
      #1;
      chk("busy_ready", dif.req_ready, 1'b0);
      chk("bus_req", dif.bus_req, (c <= addr_last));
      if (c <= addr_last) begin
        chk("bus_addr", dif.bus_addr, addr & 32'hFFFF_FFFC);
        chk("bus_wr", dif.bus_wr, we);
        chk("bus_wstrb", dif.bus_wstrb, wstrb);
        chk("bus_wdata", dif.bus_wdata, wdata);
      end
      exp_rv = (c == resp_cyc) && !cancel;
      chk("resp_valid", dif.resp_valid, exp_rv);
      if (dif.resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'h1, 32'h0);
        end else begin
          word = exp_q.pop_front();
          chk("resp_rdata", dif.resp_rdata, word);
        end
        chk("resp_err", dif.resp_err, 1'b0);
      end
    end

    @(negedge clk);
    idle_inputs();
    #1;
    chk("idle_ready", dif.req_ready, 1'b1);
    chk("idle_bus_req", dif.bus_req, 1'b0);
    chk("idle_resp_valid", dif.resp_valid, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ad, dd, rc, fl;
    bit same;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_ready", dif.req_ready, 1'b1);
    chk("rst_resp_valid", dif.resp_valid, 1'b0);
    chk("rst_resp_rdata", dif.resp_rdata, 32'h0);
    chk("rst_resp_err", dif.resp_err, 1'b0);
    chk("rst_bus_req", dif.bus_req, 1'b0);
    chk("rst_bus_wr", dif.bus_wr, 1'b0);
    chk("rst_bus_addr", dif.bus_addr, 32'h0);
    chk("rst_bus_wstrb", dif.bus_wstrb, 4'h0);
    chk("rst_bus_wdata", dif.bus_wdata, 32'h0);
    rst = 1'b0;

    // Load with an unaligned address and a delayed addr_ok. The response
    // comes 5 cycles after acceptance.
    run_txn(1'b0, 32'h1000_0006, 4'h0, 32'h0, 32'hDEAD_BEEF, 2, 0, 1'b0, 0);
    // Store with partial byte enables. The response data must be zero.
    run_txn(1'b1, 32'h0000_0020, 4'b0011, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 0, 1'b0, 0);
    // Store with no byte enables still runs the full bus transaction.
    run_txn(1'b1, 32'h0000_0104, 4'b0000, 32'hCAFE_F00D, 32'h5555_5555, 1, 1, 1'b0, 0);
    // Flush during DATA of a load: the bus completes but there is no response.
    run_txn(1'b0, 32'h0000_0040, 4'h0, 32'h0, 32'h0BAD_0BAD, 0, 2, 1'b0, 2);
    // The next request is accepted in IDLE. addr_ok and data_ok come together.
    run_txn(1'b0, 32'h0000_0048, 4'h0, 32'h0, 32'h1111_2222, 0, 0, 1'b1, 0);
    // Back-to-back request right after the previous one returned to IDLE.
    run_txn(1'b0, 32'h0000_004C, 4'h0, 32'h0, 32'h3333_4444, 0, 0, 1'b1, 0);
    // Flush in RESP suppresses the pulse.
    run_txn(1'b0, 32'h0000_0050, 4'h0, 32'h0, 32'h7777_8888, 0, 0, 1'b0, 3);
    // Flush in ADDR sets the cancel flag and the bus still completes.
    run_txn(1'b1, 32'h0000_0054, 4'hF, 32'hA5A5_5A5A, 32'h0, 3, 0, 1'b0, 1);
    // After the cancel, a plain load gets its response again.
    run_txn(1'b0, 32'h0000_0058, 4'h0, 32'h0, 32'h9999_AAAA, 0, 1, 1'b0, 0);

    // A flush together with req_valid in IDLE drops the request.
    dif.req_valid = 1'b1;
    dif.req_addr  = 32'h0000_0060;
    dif.flush     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("drop_ready", dif.req_ready, 1'b1);
    chk("drop_bus_req", dif.bus_req, 1'b0);

    // Reset asserted in DATA abandons the transaction.
    dif.req_valid = 1'b1;
    dif.req_we    = 1'b0;
    dif.req_addr  = 32'h0000_0070;
    @(posedge clk);
    @(negedge clk);
    dif.req_valid   = 1'b0;
    dif.bus_addr_ok = 1'b1;
    #1;
    chk("rstd_addr_phase", dif.bus_req, 1'b1);
    @(negedge clk);
    dif.bus_addr_ok = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstd_data_phase", dif.bus_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstd_ready", dif.req_ready, 1'b1);
    chk("rstd_bus_req", dif.bus_req, 1'b0);
    chk("rstd_resp_valid", dif.resp_valid, 1'b0);
    chk("rstd_bus_addr", dif.bus_addr, 32'h0);
    @(negedge clk);
    #1;
    chk("rstd_no_late_resp", dif.resp_valid, 1'b0);

`ifdef DMEM_TIMEOUT_EN
    // Watchdog: addr_ok never comes. RESP with error after 16 ADDR cycles.
    dif.req_valid = 1'b1;
    dif.req_we    = 1'b0;
    dif.req_addr  = 32'h0000_0080;
    #1;
    chk("wd_accept_ready", dif.req_ready, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      dif.req_valid = 1'b0;
      dif.bus_rdata = $urandom;
      #1;
      if (c <= 16) begin
        chk("wd_bus_req", dif.bus_req, 1'b1);
        chk("wd_no_resp", dif.resp_valid, 1'b0);
      end else begin
        chk("wd_resp_valid", dif.resp_valid, 1'b1);
        chk("wd_resp_err", dif.resp_err, 1'b1);
        chk("wd_resp_rdata", dif.resp_rdata, 32'h0);
        chk("wd_bus_req_off", dif.bus_req, 1'b0);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    chk("wd_idle_ready", dif.req_ready, 1'b1);
`else
    // Without the watchdog a long address-phase stall is simply waited out.
    run_txn(1'b0, 32'h0000_0080, 4'h0, 32'h0, 32'hFEED_FACE, 40, 3, 1'b0, 0);
`endif

    // Randomized transactions. The delays stay well under the watchdog limit.
    for (int t = 0; t < 24; t++) begin
      ad   = $urandom_range(0, 5);
      dd   = $urandom_range(0, 5);
      same = ($urandom_range(0, 3) == 0);
      rc   = same ? (ad + 2) : (ad + 3 + dd);
      fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rc) : 0;
      run_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, $urandom,
              ad, dd, same, fl);
    end

    chk("scoreboard_empty", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning the data width; only 32 is supported.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, meaning the bus watchdog limit in cycles; used only with DMEM_TIMEOUT_EN.
REQ-004 SHALL have the following ports:
- clk  in  1  the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  backend load/store request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wstrb  in  4  store byte enables.
- req_wdata  in  32  store data.
- req_ready  out  1  request accepted this cycle.
- flush  in  1  pipeline flush; cancels the pending response.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load data.
- resp_err  out  1  bus error/timeout flag.
- bus_req  out  1  memory-side request.
- bus_wr  out  1  memory-side write.
- bus_addr  out  ADDR_W  memory-side address, word aligned.
- bus_wstrb  out  4  memory-side byte enables.
- bus_wdata  out  32  memory-side write data.
- bus_addr_ok  in  1  address phase accepted.
- bus_data_ok  in  1  data phase complete.
- bus_rdata  in  32  memory-side read data.

Function
REQ-005 SHALL implement the FSM states IDLE, ADDR, DATA and RESP.
REQ-006 IDLE: SHALL drive req_ready=1; on req_valid&&!flush, SHALL latch we/addr/wstrb/wdata and go to ADDR the next cycle.
REQ-007 req_ready SHALL be 0 in ADDR, DATA and RESP; at most one transaction is outstanding.
REQ-008 ADDR: SHALL hold bus_req=1 with bus_wr, bus_addr={addr[ADDR_W-1:2],2'b00}, bus_wstrb and bus_wdata stable from the latched values; on bus_addr_ok SHALL go to DATA.
REQ-009 bus_req SHALL be deasserted in every state other than ADDR.
REQ-010 DATA: on bus_data_ok SHALL capture bus_rdata (loads) and go to RESP.
REQ-011 RESP: SHALL assert resp_valid for exactly one cycle, then go to IDLE.
REQ-011a Minimum latency from acceptance to resp_valid: 3 cycles (addr_ok and data_ok each granted on the first cycle offered).
REQ-012 resp_rdata SHALL hold the captured word while resp_valid=1 and SHALL be 0 for stores; byte/half extraction is done by the backend.
REQ-013 A store with req_wstrb=4'b0000 SHALL still complete a full bus transaction.
REQ-014 Flush in ADDR/DATA SHALL set a cancel flag; the bus transaction SHALL still complete (no abandoned handshake), and resp_valid SHALL be suppressed for it.
REQ-015 Flush in RESP SHALL suppress resp_valid; the FSM SHALL return to IDLE.
REQ-016 Flush in IDLE together with req_valid SHALL drop the request.
REQ-016a The cancel flag SHALL be cleared on entry to IDLE.
REQ-017 If bus_addr_ok and bus_data_ok are asserted in the same ADDR cycle, the FSM SHALL treat the data as delivered and go directly to RESP.

Reset
REQ-018 On rst=1 at a clk edge, the FSM SHALL enter IDLE, all latched fields and the cancel flag SHALL clear, and any in-flight transaction SHALL be abandoned.
REQ-019 Reset output values SHALL be: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, bus_req=0, bus_wr=0, bus_addr=0, bus_wstrb=0, bus_wdata=0.

Configuration
REQ-020 With macro DMEM_TIMEOUT_EN defined, an 8-bit-or-wider watchdog counter SHALL count cycles spent in ADDR+DATA; on reaching TIMEOUT_CYC the FSM SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-020a The watchdog counter SHALL reset on each new acceptance.
REQ-021 Without DMEM_TIMEOUT_EN, no counter SHALL exist, resp_err SHALL be tied to 0, and the FSM SHALL wait indefinitely.

Verification
REQ-022 SHALL cover: load addr=0x1000_0006, addr_ok after 2 cycles, data_ok after 1 cycle, rdata=0xDEADBEEF -> bus_addr=0x1000_0004, resp_valid one cycle with rdata=0xDEADBEEF, 5 cycles after acceptance.
REQ-023 SHALL cover: store addr=0x20, wstrb=4'b0011, wdata=0x1234ABCD -> bus_wr=1, bus_wstrb=4'b0011, resp_valid=1, resp_rdata=0.
REQ-024 SHALL cover: flush during DATA of a load -> bus handshake completes, no resp_valid; next request accepted in IDLE.
REQ-025 SHALL cover: addr_ok and data_ok in the same cycle -> resp_valid on the next cycle; back-to-back requests -> req_ready low until IDLE.
REQ-026 SHALL cover: rst asserted in DATA -> next cycle bus_req=0, req_ready=1, no resp_valid.
REQ-027 SHALL cover, with DMEM_TIMEOUT_EN and TIMEOUT_CYC=16, bus never asserting addr_ok -> resp_valid=1, resp_err=1 after 16 cycles in ADDR.
